// File: rtl/miinst_issue_sequencer_pkg.sv
// ============================================================================
// miinst_issue_sequencer_pkg
//   Shared micro-instruction types, slot indices and sequencer state encoding.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package miinst_issue_sequencer_pkg;

  // Slot positions inside a decoded bundle; index order is issue order
  localparam int MQ_SCALE = 0;
  localparam int MQ_LOAD  = 1;
  localparam int MQ_ARITH = 2;
  localparam int MQ_STORE = 3;
  localparam int MQ_RSRV1 = 4;
  localparam int MQ_RSRV2 = 5;
  localparam int MQ_RSRV3 = 6;
  localparam int MQ_RSRV4 = 7;
  localparam int MQ_N     = 8;

  typedef logic [31:0] addr_t;

  typedef enum logic [3:0] {
    MIOP_NOP   = 4'd0,
    MIOP_SCALE = 4'd1,
    MIOP_LOAD  = 4'd2,
    MIOP_ADD   = 4'd3,
    MIOP_SUB   = 4'd4,
    MIOP_STORE = 4'd5,
    MIOP_MOV   = 4'd6
  } miop_t;

  typedef struct packed {
    miop_t       op;
    logic [4:0]  dst;
    logic [4:0]  src;
    logic [17:0] imm;
  } miinst_t;

  typedef enum logic [0:0] {
    SEQ_IDLE  = 1'b0,
    SEQ_ISSUE = 1'b1
  } seq_state_t;

  function automatic logic is_real(input miinst_t m);
    return (m.op != MIOP_NOP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/miinst_slot_pick.sv
// ============================================================================
// miinst_slot_pick
//   Combinational lowest-set-bit picker: index, one-hot and any-set flag.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module miinst_slot_pick #(
  parameter int N_SLOT = 8
) (
  input  logic [N_SLOT-1:0]         req,
  output logic [$clog2(N_SLOT)-1:0] idx,
  output logic [N_SLOT-1:0]         onehot,
  output logic                      any
);

  localparam int IDX_W = $clog2(N_SLOT);

  // Scanning downward lets the lowest set bit win the last assignment
  always_comb begin
    idx = '0;
    for (int i = N_SLOT - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign onehot = req & (~req + N_SLOT'(1));
  assign any    = |req;

endmodule

`default_nettype wire

// File: rtl/miinst_issue_sequencer.sv
// ============================================================================
// miinst_issue_sequencer
//   Drains one decoded bundle of micro-instruction slots into execute, one
//   non-nop slot per cycle, tagging the last one and dropping the rest on flush.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module miinst_issue_sequencer
  import miinst_issue_sequencer_pkg::*;
#(
  parameter int N_SLOT = MQ_N,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bundle_valid,
  output logic                       bundle_ready,
  input  miinst_t [N_SLOT-1:0]       bundle,
  input  addr_t                      bundle_pc,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output miinst_t                    issue_inst,
  output addr_t                      issue_pc,
  output logic [$clog2(N_SLOT)-1:0]  issue_slot,
  output logic                       issue_last,
  input  logic                       flush,
  output logic                       busy,
  output logic [CNT_W-1:0]           issued_cnt
);

  localparam int IDX_W = $clog2(N_SLOT);

  seq_state_t            state;
  logic [N_SLOT-1:0]     pend_mask;
  logic [N_SLOT-1:0]     real_mask;
  miinst_t [N_SLOT-1:0]  held;

  logic [IDX_W-1:0]      first_idx;
  logic [N_SLOT-1:0]     first_oh;
  logic                  first_any;
  logic [IDX_W-1:0]      next_idx;
  logic [N_SLOT-1:0]     next_oh;
  logic                  next_any;

  logic                  accept;
  logic                  fire;
  logic                  last_fire;
  logic [N_SLOT-1:0]     first_rest;
  logic [N_SLOT-1:0]     next_rest;

  generate
    for (genvar g = 0; g < N_SLOT; g++) begin : g_real
      assign real_mask[g] = is_real(bundle[g]);
    end
  endgenerate

  miinst_slot_pick #(.N_SLOT(N_SLOT)) u_pick_first (
    .req    (real_mask),
    .idx    (first_idx),
    .onehot (first_oh),
    .any    (first_any)
  );

  miinst_slot_pick #(.N_SLOT(N_SLOT)) u_pick_next (
    .req    (pend_mask),
    .idx    (next_idx),
    .onehot (next_oh),
    .any    (next_any)
  );

  assign issue_valid = (state == SEQ_ISSUE);
  assign fire        = issue_valid && issue_ready;
  assign last_fire   = fire && !next_any;

  // Ready on the final handshake too, so consecutive bundles issue without a bubble
  assign bundle_ready = !rst && !flush && ((state == SEQ_IDLE) || last_fire);
  assign accept       = bundle_valid && bundle_ready;

  assign busy       = issue_valid && !issue_last;
  assign first_rest = real_mask & ~first_oh;
  assign next_rest  = pend_mask & ~next_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEQ_IDLE;
      pend_mask  <= '0;
      held       <= '0;
      issue_inst <= '0;
      issue_pc   <= '0;
      issue_slot <= '0;
      issue_last <= 1'b0;
    end else if (flush) begin
      state      <= SEQ_IDLE;
      pend_mask  <= '0;
      issue_last <= 1'b0;
    end else if (accept) begin
      held <= bundle;
      if (first_any) begin
        state      <= SEQ_ISSUE;
        issue_inst <= bundle[first_idx];
        issue_pc   <= bundle_pc;
        issue_slot <= first_idx;
        pend_mask  <= first_rest;
        issue_last <= (first_rest == '0);
      end else begin
        // All-nop bundle is consumed with nothing to issue
        state      <= SEQ_IDLE;
        pend_mask  <= '0;
        issue_last <= 1'b0;
      end
    end else if (fire) begin
      if (next_any) begin
        issue_inst <= held[next_idx];
        issue_slot <= next_idx;
        pend_mask  <= next_rest;
        issue_last <= (next_rest == '0);
      end else begin
        state      <= SEQ_IDLE;
        issue_last <= 1'b0;
      end
    end
  end

  // A handshake still counts in a flush cycle; the consumer decides its fate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt <= '0;
    end else if (fire) begin
      issued_cnt <= issued_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_miinst_issue_sequencer.sv
// ============================================================================
// tb_miinst_issue_sequencer
//   Directed, table-driven and randomized checks against a queue-based model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_miinst_issue_sequencer;
  import miinst_issue_sequencer_pkg::*;

  localparam int N  = MQ_N;
  localparam int IW = $clog2(N);

  typedef miinst_t [N-1:0] bundle_t;
  typedef struct packed {
    miinst_t       inst;
    logic [IW-1:0] slot;
  } item_t;
  typedef struct {
    logic [N-1:0] mask;
    int           n;
    int           first;
    int           last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bundle_valid = 1'b0;
  logic          issue_ready = 1'b0;
  logic          flush = 1'b0;
  bundle_t       bundle = '0;
  addr_t         bundle_pc = '0;

  logic          bundle_ready, issue_valid, issue_last, busy;
  miinst_t       issue_inst;
  addr_t         issue_pc;
  logic [IW-1:0] issue_slot;
  logic [31:0]   issued_cnt;

  logic          bundle_ready2, issue_valid2, issue_last2, busy2;
  miinst_t       issue_inst2;
  addr_t         issue_pc2;
  logic [IW-1:0] issue_slot2;
  logic [2:0]    cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  miinst_issue_sequencer #(.N_SLOT(N), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
    .bundle(bundle), .bundle_pc(bundle_pc), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_inst(issue_inst), .issue_pc(issue_pc),
    .issue_slot(issue_slot), .issue_last(issue_last), .flush(flush), .busy(busy),
    .issued_cnt(issued_cnt)
  );

  miinst_issue_sequencer #(.N_SLOT(N), .CNT_W(3)) dut_w3 (
    .clk(clk), .rst(rst), .bundle_valid(bundle_valid), .bundle_ready(bundle_ready2),
    .bundle(bundle), .bundle_pc(bundle_pc), .issue_valid(issue_valid2),
    .issue_ready(issue_ready), .issue_inst(issue_inst2), .issue_pc(issue_pc2),
    .issue_slot(issue_slot2), .issue_last(issue_last2), .flush(flush), .busy(busy2),
    .issued_cnt(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bundle_t mk(input logic [N-1:0] mask, input logic [4:0] tag);
    bundle_t b;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) b[i] = '{op: miop_t'(4'(1 + (i % 6))), dst: 5'(i), src: tag, imm: 18'($urandom)};
      else         b[i] = '{op: MIOP_NOP, dst: 5'($urandom), src: 5'($urandom), imm: 18'($urandom)};
    end
    return b;
  endfunction

  // Reference model: the bundle becomes a queue of its non-nop slots in index order
  item_t       q[$];
  item_t       cur = '0;
  logic        m_valid = 1'b0;
  addr_t       m_pc = '0;
  logic [31:0] m_cnt = '0;

  function automatic logic m_bready();
    return !flush && (!m_valid || (issue_ready && q.size() == 0));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      m_pc    = '0;
      m_cnt   = '0;
    end else begin
      logic f, a;
      f = m_valid && issue_ready;
      a = bundle_valid && m_bready();
      if (f) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        m_valid = 1'b0;
        q.delete();
      end else if (a) begin
        q.delete();
        for (int i = 0; i < N; i++)
          if (bundle[i].op != MIOP_NOP) q.push_back('{inst: bundle[i], slot: IW'(i)});
        m_pc = bundle_pc;
        if (q.size() > 0) begin
          cur = q.pop_front();
          m_valid = 1'b1;
        end else m_valid = 1'b0;
      end else if (f) begin
        if (q.size() > 0) cur = q.pop_front();
        else m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_issue_valid", 96'(issue_valid), 96'(m_valid));
      chk("m_bundle_ready", 96'(bundle_ready), 96'(m_bready()));
      chk("m_busy", 96'(busy), 96'(m_valid && q.size() != 0));
      chk("m_issued_cnt", 96'(issued_cnt), 96'(m_cnt));
      chk("m_w3_ctl", 96'({issue_valid2, bundle_ready2, busy2, cnt2}),
          96'({m_valid, m_bready(), m_valid && q.size() != 0, m_cnt[2:0]}));
      if (m_valid) begin
        chk("m_issue_inst", 96'(issue_inst), 96'(cur.inst));
        chk("m_issue_pc", 96'(issue_pc), 96'(m_pc));
        chk("m_issue_slot", 96'(issue_slot), 96'(cur.slot));
        chk("m_issue_last", 96'(issue_last), 96'(q.size() == 0));
        chk("m_w3_payload", 96'({issue_inst2, issue_pc2, issue_slot2, issue_last2}),
            96'({cur.inst, m_pc, cur.slot, q.size() == 0}));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bundle_valid = 1'b0;
    flush        = 1'b0;
    issue_ready  = 1'b1;
    for (int k = 0; k < 40 && issue_valid; k++) cyc();
    cyc();
    chk("drain_idle", 96'(issue_valid), 96'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t    vt[6];
    bundle_t bA, bB;
    addr_t   pA, pB;
    logic [31:0] snap;
    int nseen, fseen, lseen;

    vt[0] = '{8'b0000_1110, 3, MQ_LOAD, MQ_STORE};
    vt[1] = '{8'b0000_0000, 0, 0, 0};
    vt[2] = '{8'b1000_0000, 1, 7, 7};
    vt[3] = '{8'b1000_0001, 2, 0, 7};
    vt[4] = '{8'b1111_1111, 8, 0, 7};
    vt[5] = '{8'b0101_0100, 3, 2, 6};

    // Reset values, with a bundle offered during reset
    bundle_valid = 1'b1;
    bundle       = mk(8'hFF, 5'd1);
    #12;
    chk("rst_bundle_ready", 96'(bundle_ready), 96'(0));
    chk("rst_issue_valid", 96'(issue_valid), 96'(0));
    chk("rst_outputs", 96'({issue_inst, issue_pc, issue_slot, issue_last, busy}), 96'(0));
    chk("rst_cnt", 96'(issued_cnt), 96'(0));
    bundle_valid = 1'b0;
    cyc();
    rst = 1'b0;

    // LOAD/ARITH/STORE bundle
    cyc();
    bA = mk(8'b0000_1110, 5'd2);
    bundle = bA; bundle_pc = 32'h0040_0000; bundle_valid = 1'b1; issue_ready = 1'b1;
    #2 chk("t1_accept", 96'(bundle_ready), 96'(1));
    cyc(); bundle_valid = 1'b0;
    #2 chk("t1_i0", 96'({issue_valid, issue_slot, issue_last, issue_pc}), 96'({1'b1, 3'(MQ_LOAD), 1'b0, 32'h0040_0000}));
    chk("t1_i0_inst", 96'(issue_inst), 96'(bA[MQ_LOAD]));
    cyc();
    #2 chk("t1_i1", 96'({issue_valid, issue_slot, issue_last}), 96'({1'b1, 3'(MQ_ARITH), 1'b0}));
    cyc();
    #2 chk("t1_i2", 96'({issue_valid, issue_slot, issue_last}), 96'({1'b1, 3'(MQ_STORE), 1'b1}));
    cyc();
    #2 chk("t1_done", 96'(issue_valid), 96'(0));

    // Table of bundle shapes, each drained at full rate
    for (int t = 0; t < 6; t++) begin
      drain();
      snap = m_cnt;
      bundle = mk(vt[t].mask, 5'(t)); bundle_pc = $urandom; bundle_valid = 1'b1;
      #2 chk("tab_accept", 96'(bundle_ready), 96'(1));
      cyc(); bundle_valid = 1'b0;
      nseen = 0; fseen = -1; lseen = -1;
      for (int c = 0; c < N + 2; c++) begin
        #2;
        if (issue_valid) begin
          nseen++;
          if (nseen == 1) fseen = int'(issue_slot);
          if (issue_last) lseen = int'(issue_slot);
        end
        cyc();
      end
      chk("tab_count", 96'(nseen), 96'(vt[t].n));
      chk("tab_cnt_delta", 96'(issued_cnt - snap), 96'(vt[t].n));
      if (vt[t].n > 0) begin
        chk("tab_first", 96'(fseen), 96'(vt[t].first));
        chk("tab_last", 96'(lseen), 96'(vt[t].last));
      end
    end

    // Back-to-back bundles, valid held, zero bubble between them
    drain();
    bA = mk(8'b0011_0001, 5'd3); pA = 32'h1000;
    bB = mk(8'b0100_0000, 5'd4); pB = 32'h2000;
    bundle = bA; bundle_pc = pA; bundle_valid = 1'b1;
    #2 chk("b2b_acc_a", 96'(bundle_ready), 96'(1));
    cyc(); bundle = bB; bundle_pc = pB;
    #2 chk("b2b_i0", 96'({issue_valid, issue_slot, bundle_ready}), 96'({1'b1, 3'd0, 1'b0}));
    cyc();
    #2 chk("b2b_i1", 96'({issue_valid, issue_slot, bundle_ready}), 96'({1'b1, 3'd4, 1'b0}));
    cyc();
    #2 chk("b2b_i2", 96'({issue_valid, issue_slot, issue_last, bundle_ready}), 96'({1'b1, 3'd5, 1'b1, 1'b1}));
    cyc(); bundle_valid = 1'b0;
    #2 chk("b2b_i3", 96'({issue_valid, issue_slot, issue_last, issue_pc}), 96'({1'b1, 3'd6, 1'b1, pB}));
    cyc();
    #2 chk("b2b_done", 96'(issue_valid), 96'(0));

    // All-nop bundle
    drain();
    snap = m_cnt;
    bundle = mk(8'h00, 5'd5); bundle_valid = 1'b1;
    #2 chk("nop_accept", 96'(bundle_ready), 96'(1));
    cyc(); bundle_valid = 1'b0;
    #2 chk("nop_no_issue", 96'(issue_valid), 96'(0));
    cyc();
    #2 chk("nop_cnt", 96'(issued_cnt), 96'(snap));

    // Five-cycle stall mid-bundle
    drain();
    bA = mk(8'b0000_0111, 5'd6); pA = 32'h3000;
    bundle = bA; bundle_pc = pA; bundle_valid = 1'b1;
    cyc(); bundle = mk(8'h10, 5'd7); issue_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #2 chk("stall_hold", 96'({issue_valid, issue_slot, issue_pc, issue_inst, bundle_ready}),
             96'({1'b1, 3'd0, pA, bA[0], 1'b0}));
      cyc();
    end
    bundle_valid = 1'b0; issue_ready = 1'b1;
    #2 chk("stall_release", 96'({issue_valid, issue_slot}), 96'({1'b1, 3'd0}));

    // Flush on the second of four issues
    drain();
    bA = mk(8'b1010_1010, 5'd8); pA = 32'h4000;
    bB = mk(8'b0000_0100, 5'd9); pB = 32'h5000;
    bundle = bA; bundle_pc = pA; bundle_valid = 1'b1;
    cyc(); bundle_valid = 1'b0;
    #2 chk("fl_i0", 96'(issue_slot), 96'(1));
    cyc(); flush = 1'b1; bundle = bB; bundle_pc = pB; bundle_valid = 1'b1;
    snap = m_cnt;
    #2 chk("fl_i1", 96'({issue_valid, issue_slot, bundle_ready}), 96'({1'b1, 3'd3, 1'b0}));
    cyc(); flush = 1'b0;
    #2 chk("fl_after", 96'({issue_valid, bundle_ready}), 96'({1'b0, 1'b1}));
    chk("fl_cnt", 96'(issued_cnt), 96'(snap + 32'd1));
    cyc(); bundle_valid = 1'b0;
    #2 chk("fl_new", 96'({issue_valid, issue_slot, issue_last, issue_pc}), 96'({1'b1, 3'd2, 1'b1, pB}));
    cyc();
    #2 chk("fl_done", 96'(issue_valid), 96'(0));

    // Asynchronous reset mid-bundle
    drain();
    bundle = mk(8'hFF, 5'd10); bundle_pc = 32'h6000; bundle_valid = 1'b1;
    cyc(); bundle_valid = 1'b0;
    cyc(); bundle_valid = 1'b1;
    #2 rst = 1'b1;
    #1 chk("arst_valid", 96'({issue_valid, bundle_ready, busy}), 96'(0));
    chk("arst_payload", 96'({issue_inst, issue_pc, issue_slot, issue_last}), 96'(0));
    chk("arst_cnt", 96'({issued_cnt, cnt2}), 96'(0));
    @(posedge clk); #3;
    bundle_valid = 1'b0;
    rst = 1'b0;

    // Counter wrap on the 3-bit instance
    cyc();
    bundle = mk(8'hFF, 5'd11); bundle_valid = 1'b1; issue_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(); bundle_valid = 1'b0;
    end
    #2 chk("wrap_pre", 96'({issue_last, cnt2}), 96'({1'b1, 3'd7}));
    cyc();
    #2 chk("wrap_post", 96'({cnt2, issued_cnt}), 96'({3'd0, 32'd8}));

    // Randomized traffic against the model
    for (int r = 0; r < 3000; r++) begin
      cyc();
      bundle_valid = ($urandom % 10) < 6;
      bundle       = mk(N'($urandom) & N'($urandom), 5'($urandom));
      bundle_pc    = $urandom;
      issue_ready  = ($urandom % 4) != 0;
      flush        = ($urandom % 20) == 0;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
